// File: rtl/eth_rx_commit_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_commit_fifo_pkg
// Description : Shared types and constants for the commit-on-FCS RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_commit_fifo_pkg;

    localparam int FRAME_LEN_BITS = 16;

    typedef enum logic [1:0] {
        WR_IDLE     = 2'd0,
        WR_FRAME    = 2'd1,
        WR_OVERFLOW = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_FRAME = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
    } EthernetRxBus;

    // Number of 32-bit words needed to hold a frame of the given byte length.
    function automatic logic [FRAME_LEN_BITS-2:0] len_to_words(input logic [FRAME_LEN_BITS-1:0] len);
        return {1'b0, len[FRAME_LEN_BITS-1:2]} + {{(FRAME_LEN_BITS-2){1'b0}}, |len[1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_commit_ram.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_commit_ram
// Description : Simple dual-port RAM with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_commit_ram #(
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 35,
    parameter int USE_BLOCK = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    generate
        if (USE_BLOCK != 0) begin : g_block
            (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];
            logic [WIDTH-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (i_we) begin
                    r_mem[i_waddr] <= i_wdata;
                end
                if (i_re) begin
                    r_rdata <= r_mem[i_raddr];
                end
            end
            assign o_rdata = r_rdata;
        end else begin : g_dist
            (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];
            logic [WIDTH-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (i_we) begin
                    r_mem[i_waddr] <= i_wdata;
                end
                if (i_re) begin
                    r_rdata <= r_mem[i_raddr];
                end
            end
            assign o_rdata = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/eth_rx_commit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_commit_fifo
// Description : MAC RX frame buffer; frames become readable only on commit,
//               dropped/preempted/overflowing frames are rolled back.
//               Optional counters: define ETH_RX_COMMIT_FIFO_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_commit_fifo
    import eth_rx_commit_fifo_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int FRAME_DEPTH = 32,
    parameter int USE_BLOCK   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  EthernetRxBus              rx_bus,
    output logic                      rd_frame_valid,
    output logic [FRAME_LEN_BITS-1:0] rd_frame_len,
    input  logic                      rd_en,
    output logic                      rd_data_valid,
    output logic [31:0]               rd_data,
    output logic [2:0]                rd_bytes_valid,
    output logic                      rd_last,
    output logic                      overflow
`ifdef ETH_RX_COMMIT_FIFO_STATS_EN
    ,
    output logic [31:0]               stat_commits,
    output logic [31:0]               stat_drops,
    output logic [31:0]               stat_overflows
`endif
);

    localparam int             c_aw        = $clog2(DEPTH);
    localparam int             c_law       = $clog2(FRAME_DEPTH);
    localparam logic [c_aw:0]  c_ptr_one   = {{c_aw{1'b0}}, 1'b1};
    localparam logic [c_law:0] c_lptr_one  = {{c_law{1'b0}}, 1'b1};
    localparam int             c_wl_bits   = FRAME_LEN_BITS - 1;

    // ---------------- write side state ----------------
    wr_state_t                 r_wr_state;
    wr_state_t                 w_wr_state_nxt;
    logic [c_aw:0]             r_wr_ptr;
    logic [c_aw:0]             w_wr_ptr_nxt;
    logic [c_aw:0]             r_commit_ptr;
    logic [c_aw:0]             w_commit_ptr_nxt;
    logic [c_aw:0]             r_rd_ptr;
    logic [FRAME_LEN_BITS-1:0] r_frame_bytes;
    logic [FRAME_LEN_BITS-1:0] w_frame_bytes_nxt;
    logic                      w_ram_we;
    logic                      w_len_push;
    logic                      w_ovf;
    logic                      r_overflow;
    logic                      w_full;

    // ---------------- length FIFO ----------------
    logic [FRAME_LEN_BITS-1:0] r_len_mem [FRAME_DEPTH];
    logic [c_law:0]            r_len_wr;
    logic [c_law:0]            r_len_rd;
    logic                      w_len_full;
    logic                      w_len_empty;
    logic [FRAME_LEN_BITS-1:0] w_head_len;

    // ---------------- read side state ----------------
    rd_state_t                 r_rd_state;
    rd_state_t                 w_rd_state_nxt;
    logic [c_wl_bits-1:0]      r_words_left;
    logic [c_wl_bits-1:0]      w_words_cur;
    logic                      w_rd_accept;
    logic                      w_rd_last_word;
    logic                      w_len_pop;
    logic                      r_rd_dv;
    logic                      r_rd_last;
    logic [34:0]               w_ram_q;

    assign w_full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                         (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_len_full  = (r_len_wr[c_law] != r_len_rd[c_law]) &&
                         (r_len_wr[c_law-1:0] == r_len_rd[c_law-1:0]);
    assign w_len_empty = (r_len_wr == r_len_rd);
    assign w_head_len  = r_len_mem[r_len_rd[c_law-1:0]];

    // Write FSM: a data word in the commit cycle is stored before the commit
    // takes effect, so commit uses the "next" pointer and byte count.
    always_comb begin
        w_wr_state_nxt    = r_wr_state;
        w_wr_ptr_nxt      = r_wr_ptr;
        w_commit_ptr_nxt  = r_commit_ptr;
        w_frame_bytes_nxt = r_frame_bytes;
        w_ram_we          = 1'b0;
        w_len_push        = 1'b0;
        w_ovf             = 1'b0;
        if (rx_bus.start) begin
            w_wr_ptr_nxt      = r_commit_ptr;
            w_frame_bytes_nxt = '0;
            w_wr_state_nxt    = WR_FRAME;
        end else begin
            case (r_wr_state)
                WR_FRAME: begin
                    if (rx_bus.data_valid) begin
                        if (w_full) begin
                            w_wr_ptr_nxt   = r_commit_ptr;
                            w_ovf          = 1'b1;
                            w_wr_state_nxt = WR_OVERFLOW;
                        end else begin
                            w_ram_we          = 1'b1;
                            w_wr_ptr_nxt      = r_wr_ptr + c_ptr_one;
                            w_frame_bytes_nxt = r_frame_bytes + {13'd0, rx_bus.bytes_valid};
                        end
                    end
                    if (w_ovf) begin
                        if (rx_bus.commit || rx_bus.drop) begin
                            w_wr_state_nxt = WR_IDLE;
                        end
                    end else if (rx_bus.commit) begin
                        if (!w_len_full && (w_frame_bytes_nxt != '0)) begin
                            w_len_push       = 1'b1;
                            w_commit_ptr_nxt = w_wr_ptr_nxt;
                        end else begin
                            w_wr_ptr_nxt = r_commit_ptr;
                            w_ovf        = w_len_full;
                        end
                        w_wr_state_nxt = WR_IDLE;
                    end else if (rx_bus.drop) begin
                        w_wr_ptr_nxt   = r_commit_ptr;
                        w_wr_state_nxt = WR_IDLE;
                    end
                end
                WR_OVERFLOW: begin
                    if (rx_bus.commit || rx_bus.drop) begin
                        w_wr_state_nxt = WR_IDLE;
                    end
                end
                default: begin
                    w_wr_state_nxt = r_wr_state;
                end
            endcase
        end
    end

    // Read FSM: the word count of the head frame is taken on the first pop.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_words_cur    = (r_rd_state == RD_IDLE) ? len_to_words(w_head_len) : r_words_left;
        w_rd_accept    = rd_en && !w_len_empty;
        w_rd_last_word = (w_words_cur == {{(c_wl_bits-1){1'b0}}, 1'b1});
        w_len_pop      = w_rd_accept && w_rd_last_word;
        if (w_rd_accept) begin
            w_rd_state_nxt = w_rd_last_word ? RD_IDLE : RD_FRAME;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_state    <= WR_IDLE;
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_frame_bytes <= '0;
            r_overflow    <= 1'b0;
            r_len_wr      <= '0;
            r_len_rd      <= '0;
            r_rd_state    <= RD_IDLE;
            r_rd_ptr      <= '0;
            r_words_left  <= '0;
            r_rd_dv       <= 1'b0;
            r_rd_last     <= 1'b0;
        end else begin
            r_wr_state    <= w_wr_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_commit_ptr  <= w_commit_ptr_nxt;
            r_frame_bytes <= w_frame_bytes_nxt;
            r_overflow    <= w_ovf;
            r_rd_state    <= w_rd_state_nxt;
            if (w_len_push) begin
                r_len_wr <= r_len_wr + c_lptr_one;
            end
            if (w_len_pop) begin
                r_len_rd <= r_len_rd + c_lptr_one;
            end
            if (w_rd_accept) begin
                r_rd_ptr     <= r_rd_ptr + c_ptr_one;
                r_words_left <= w_words_cur - {{(c_wl_bits-1){1'b0}}, 1'b1};
            end
            r_rd_dv   <= w_rd_accept;
            r_rd_last <= w_rd_accept && w_rd_last_word;
        end
    end

    always_ff @(posedge clk) begin
        if (w_len_push) begin
            r_len_mem[r_len_wr[c_law-1:0]] <= w_frame_bytes_nxt;
        end
    end

    eth_rx_commit_ram #(
        .DEPTH     (DEPTH),
        .WIDTH     (35),
        .USE_BLOCK (USE_BLOCK)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr[c_aw-1:0]),
        .i_wdata ({rx_bus.bytes_valid, rx_bus.data}),
        .i_re    (w_rd_accept),
        .i_raddr (r_rd_ptr[c_aw-1:0]),
        .o_rdata (w_ram_q)
    );

    // RAM output is not reset, so it is masked until a word is presented.
    assign rd_frame_valid = !w_len_empty;
    assign rd_frame_len   = w_len_empty ? '0 : w_head_len;
    assign rd_data_valid  = r_rd_dv;
    assign rd_data        = r_rd_dv ? w_ram_q[31:0] : '0;
    assign rd_bytes_valid = r_rd_dv ? w_ram_q[34:32] : '0;
    assign rd_last        = r_rd_last;
    assign overflow       = r_overflow;

`ifdef ETH_RX_COMMIT_FIFO_STATS_EN
    logic [31:0] r_stat_commits;
    logic [31:0] r_stat_drops;
    logic [31:0] r_stat_overflows;
    logic        w_drop_evt;

    assign w_drop_evt = !rx_bus.start && (r_wr_state == WR_FRAME) && rx_bus.drop && !rx_bus.commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_commits   <= '0;
            r_stat_drops     <= '0;
            r_stat_overflows <= '0;
        end else begin
            if (w_len_push && (r_stat_commits != 32'hffffffff)) begin
                r_stat_commits <= r_stat_commits + 32'd1;
            end
            if (w_drop_evt && (r_stat_drops != 32'hffffffff)) begin
                r_stat_drops <= r_stat_drops + 32'd1;
            end
            if (w_ovf && (r_stat_overflows != 32'hffffffff)) begin
                r_stat_overflows <= r_stat_overflows + 32'd1;
            end
        end
    end

    assign stat_commits   = r_stat_commits;
    assign stat_drops     = r_stat_drops;
    assign stat_overflows = r_stat_overflows;
`endif

endmodule
`default_nettype wire
